// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants and the BCD-to-segment decoder.
// Segment bit order is {g,f,e,d,c,b,a}; the decimal point is appended by the caller.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   localparam logic [6:0] SEG_GLYPH [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Codes 10-15 are not decimal digits and show a dash.
   function automatic logic [6:0] seg7_decode(input logic [3:0] i_val);
      logic [6:0] w_seg;
      if (i_val <= 4'd9) w_seg = SEG_GLYPH[i_val];
      else               w_seg = SEG_DASH;
      return w_seg;
   endfunction

endpackage

// File: rtl/pwm_fader.sv
// PWM slot generator with a one-step-per-period fade toward the target level.
// o_gate is combinational from registered state; o_level moves only at period end.
module pwm_fader #(
   parameter int CLK_FREQ    = 125_000_000,
   parameter int PWM_FREQ    = 1000,
   parameter int BRIGHT_BITS = 3
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BRIGHT_BITS-1:0] i_target,
   output logic [BRIGHT_BITS-1:0] o_level,
   output logic                   o_gate
);

   localparam int PERIOD_CYC = CLK_FREQ / PWM_FREQ;
   localparam int SLOT_RAW   = PERIOD_CYC >> BRIGHT_BITS;
   localparam int SLOT_CYC   = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
   localparam int PRE_W      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(SLOT_CYC - 1);
   localparam logic [BRIGHT_BITS-1:0] LVL_MAX  = '1;

   logic [PRE_W-1:0]       r_pre;
   logic [BRIGHT_BITS-1:0] r_slot;
   logic [BRIGHT_BITS-1:0] r_level;
   logic                   w_slot_end;
   logic                   w_period_end;

   assign w_slot_end   = (r_pre == PRE_LAST);
   assign w_period_end = w_slot_end && (r_slot == LVL_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre   <= '0;
         r_slot  <= '0;
         r_level <= '0;
      end else begin
         r_pre <= w_slot_end ? '0 : r_pre + 1'b1;
         if (w_slot_end) r_slot <= r_slot + 1'b1;
         if (w_period_end) begin
            if (r_level < i_target)      r_level <= r_level + 1'b1;
            else if (r_level > i_target) r_level <= r_level - 1'b1;
         end
      end
   end

   // Full scale bypasses the slot compare so the top level is continuously on.
   assign o_gate  = (r_level == LVL_MAX) || (r_slot < r_level);
   assign o_level = r_level;

endmodule

// File: rtl/seg7_scan_pwm_ctrl.sv
// Multiplexed 7-segment scanner: frame-latched BCD, leading-zero blanking, PWM fade.
// seg_out/digit_en are registered one cycle behind the scan index and PWM slot.
module seg7_scan_pwm_ctrl
   import seg7_pkg::*;
#(
   parameter int CLK_FREQ    = 125_000_000,
   parameter int PWM_FREQ    = 1000,
   parameter int SCAN_FREQ   = 500,
   parameter int NUM_DIGITS  = 4,
   parameter int BRIGHT_BITS = 3
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic [BRIGHT_BITS-1:0]  target_level,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic [BRIGHT_BITS-1:0]  cur_level,
   output logic [NUM_DIGITS-1:0]   bcd_valid,
   output logic                    frame_tick
);

   localparam int SCAN_RAW = CLK_FREQ / (SCAN_FREQ * NUM_DIGITS);
   localparam int SCAN_CYC = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
   localparam int SCAN_W   = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_W-1:0]       r_scan_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [7:0]              r_seg_out;
   logic [NUM_DIGITS-1:0]   r_digit_en;
   logic                    r_frame_tick;

   logic                    w_scan_end;
   logic                    w_frame_wrap;
   logic                    w_gate;
   logic [NUM_DIGITS-1:0]   w_blank;
   logic                    w_lz_run;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [NUM_DIGITS-1:0]   w_bcd_valid;
   logic [3:0]              w_cur_bcd;
   logic                    w_cur_dp;
   logic                    w_cur_blank;

   pwm_fader #(
      .CLK_FREQ    (CLK_FREQ),
      .PWM_FREQ    (PWM_FREQ),
      .BRIGHT_BITS (BRIGHT_BITS)
   ) u_fader (
      .clk      (clk),
      .reset    (reset),
      .i_target (target_level),
      .o_level  (cur_level),
      .o_gate   (w_gate)
   );

   assign w_scan_end   = (r_scan_cnt == SCAN_LAST);
   assign w_frame_wrap = w_scan_end && (r_idx == IDX_LAST);

   // Blank from the top down while digits are zero with no dp; digit 0 always shows.
   always_comb begin
      w_blank  = '0;
      w_lz_run = blank_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (w_lz_run && (r_shadow_bcd[4*i +: 4] == 4'd0) && !r_shadow_dp[i]) w_blank[i] = 1'b1;
         else w_lz_run = 1'b0;
      end
   end

   always_comb begin
      w_onehot    = '0;
      w_bcd_valid = '0;
      w_cur_bcd   = '0;
      w_cur_dp    = 1'b0;
      w_cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_bcd_valid[i] = (r_shadow_bcd[4*i +: 4] <= 4'd9);
         if (r_idx == IDX_W'(i)) begin
            w_onehot[i] = 1'b1;
            w_cur_bcd   = r_shadow_bcd[4*i +: 4];
            w_cur_dp    = r_shadow_dp[i];
            w_cur_blank = w_blank[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_cnt   <= '0;
         r_idx        <= '0;
         r_shadow_bcd <= '0;
         r_shadow_dp  <= '0;
         r_seg_out    <= '0;
         r_digit_en   <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_wrap;
         if (w_scan_end) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         if (w_frame_wrap) begin
            r_shadow_bcd <= bcd_in;
            r_shadow_dp  <= dp_in;
         end
         r_digit_en <= w_onehot;
         r_seg_out  <= (w_gate && !w_cur_blank) ? {w_cur_dp, seg7_decode(w_cur_bcd)} : {1'b0, SEG_BLANK};
      end
   end

   assign seg_out    = r_seg_out;
   assign digit_en   = r_digit_en;
   assign bcd_valid  = w_bcd_valid;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_pwm_ctrl.sv
// Directed bench for seg7_scan_pwm_ctrl: scan order, frame latch, blanking, fade and duty.
// Expected frames and fade levels are queued at stimulus time and popped as the outputs change.
module tb_seg7_scan_pwm_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [2:0]  target_level;
   logic [7:0]  seg_out;
   logic [3:0]  digit_en;
   logic [2:0]  cur_level;
   logic [3:0]  bcd_valid;
   logic        frame_tick;

   typedef struct packed {
      logic [3:0] en;
      logic [7:0] seg;
   } exp_t;

   exp_t       seg_q[$];
   logic [2:0] lvl_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] prev_en;
   logic [2:0] prev_lvl;
   int         duty;

   seg7_scan_pwm_ctrl #(
      .CLK_FREQ    (8000),
      .PWM_FREQ    (250),
      .SCAN_FREQ   (500),
      .NUM_DIGITS  (4),
      .BRIGHT_BITS (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bcd_in       (bcd_in),
      .dp_in        (dp_in),
      .blank_lz     (blank_lz),
      .target_level (target_level),
      .seg_out      (seg_out),
      .digit_en     (digit_en),
      .cur_level    (cur_level),
      .bcd_valid    (bcd_valid),
      .frame_tick   (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seg(input logic [3:0] en, input logic [7:0] seg);
      exp_t e;
      e.en  = en;
      e.seg = seg;
      seg_q.push_back(e);
   endtask

   task automatic pop_seg();
      exp_t e;
      if (seg_q.size() == 0) begin
         check("seg_sb_underflow", 32'(seg_q.size()), 32'd1);
      end else begin
         e = seg_q.pop_front();
         check("frame_digit_en", 32'(digit_en), 32'(e.en));
         check("frame_seg_out", 32'(seg_out), 32'(e.seg));
      end
   endtask

   task automatic run_frames(input int cycles);
      prev_en = digit_en;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (digit_en !== prev_en) pop_seg();
         prev_en = digit_en;
      end
      check("seg_sb_drained", 32'(seg_q.size()), 32'd0);
   endtask

   task automatic run_fade(input int cycles);
      prev_lvl = cur_level;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (cur_level !== prev_lvl) begin
            if (lvl_q.size() == 0) check("lvl_sb_underflow", 32'(lvl_q.size()), 32'd1);
            else check("fade_step", 32'(cur_level), 32'(lvl_q.pop_front()));
         end
         prev_lvl = cur_level;
      end
      check("lvl_sb_drained", 32'(lvl_q.size()), 32'd0);
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 40; i++) begin
         step();
         if (frame_tick === 1'b1) break;
      end
      check("frame_tick_seen", 32'(frame_tick), 32'd1);
   endtask

   task automatic wait_level(input logic [2:0] lvl);
      for (int i = 0; i < 400 && cur_level !== lvl; i++) step();
      check("level_reached", 32'(cur_level), 32'(lvl));
   endtask

   task automatic measure_duty(input int expected);
      duty = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (seg_out !== 8'h00) duty++;
      end
      check("pwm_duty", 32'(duty), 32'(expected));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      bcd_in       = 16'h0000;
      dp_in        = 4'b0000;
      blank_lz     = 1'b0;
      target_level = 3'd0;
      #2 reset = 1'b1;
      #20;
      check("rst_seg_out", 32'(seg_out), 32'h00);
      check("rst_digit_en", 32'(digit_en), 32'h0);
      check("rst_cur_level", 32'(cur_level), 32'h0);
      check("rst_bcd_valid", 32'(bcd_valid), 32'hF);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Scan order and frame tick cadence from reset release.
      for (int k = 1; k <= 32; k++) begin
         logic [3:0] exp_en;
         exp_en = 4'b0001 << (((k - 1) / 4) % 4);
         step();
         check("scan_digit_en", 32'(digit_en), 32'(exp_en));
         check("scan_frame_tick", 32'(frame_tick), (k % 16 == 0) ? 32'd1 : 32'd0);
      end
      measure_duty(0);

      target_level = 3'd7;
      wait_level(3'd7);
      measure_duty(32);

      // Frame latch: the input changes right after the latch and must wait a frame.
      bcd_in = 16'h1234;
      wait_tick();
      bcd_in = 16'h5678;
      push_seg(4'b0001, 8'h66); push_seg(4'b0010, 8'h4F);
      push_seg(4'b0100, 8'h5B); push_seg(4'b1000, 8'h06);
      push_seg(4'b0001, 8'h7F); push_seg(4'b0010, 8'h07);
      push_seg(4'b0100, 8'h7D); push_seg(4'b1000, 8'h6D);
      check("valid_1234", 32'(bcd_valid), 32'hF);
      run_frames(32);

      // Leading-zero blanking, then an invalid digit with a dp stopping the blanking.
      blank_lz = 1'b1;
      bcd_in   = 16'h0070;
      wait_tick();
      check("valid_0070", 32'(bcd_valid), 32'hF);
      bcd_in = 16'h00A0;
      dp_in  = 4'b0100;
      push_seg(4'b0001, 8'h3F); push_seg(4'b0010, 8'h07);
      push_seg(4'b0100, 8'h00); push_seg(4'b1000, 8'h00);
      push_seg(4'b0001, 8'h3F); push_seg(4'b0010, 8'h40);
      push_seg(4'b0100, 8'hBF); push_seg(4'b1000, 8'h00);
      run_frames(32);
      check("valid_00A0", 32'(bcd_valid), 32'hD);

      // Fade down 7 -> 2.
      blank_lz     = 1'b0;
      target_level = 3'd2;
      lvl_q.push_back(3'd6); lvl_q.push_back(3'd5); lvl_q.push_back(3'd4);
      lvl_q.push_back(3'd3); lvl_q.push_back(3'd2);
      run_fade(200);
      check("fade_down_hold", 32'(cur_level), 32'd2);
      measure_duty(8);

      // Fade up from reset to 5.
      target_level = 3'd5;
      pulse_reset();
      for (int l = 1; l <= 5; l++) lvl_q.push_back(3'(l));
      run_fade(224);
      check("fade_up_hold", 32'(cur_level), 32'd5);
      measure_duty(20);

      // Asynchronous reset mid-fade, between clock edges.
      target_level = 3'd7;
      pulse_reset();
      wait_level(3'd4);
      #3 reset = 1'b1;
      #1;
      check("async_seg_out", 32'(seg_out), 32'h00);
      check("async_digit_en", 32'(digit_en), 32'h0);
      check("async_cur_level", 32'(cur_level), 32'h0);
      check("async_frame_tick", 32'(frame_tick), 32'h0);
      check("async_bcd_valid", 32'(bcd_valid), 32'hF);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 31; i++) step();
      check("restart_level_hold", 32'(cur_level), 32'd0);
      step();
      check("restart_level_first", 32'(cur_level), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
